// File: rtl/seg7_scan_reader_if.sv
// Bus bundle for the 7-segment scan reader: sampled display lines in,
// recovered frame out on a valid/ready handshake.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                      sample_en;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                segments;
    logic [4*NUM_DIGITS-1:0]   out_value;
    logic [NUM_DIGITS-1:0]     out_ok_mask;
    logic [NUM_DIGITS-1:0]     out_blank_mask;
    logic [NUM_DIGITS-1:0]     out_err_mask;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output sample_en, an, segments, out_ready,
        input  out_value, out_ok_mask, out_blank_mask, out_err_mask, out_valid
    );

    modport slave (
        input  sample_en, an, segments, out_ready,
        output out_value, out_ok_mask, out_blank_mask, out_err_mask, out_valid
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus; each digit
// must repeat STABLE_CNT times before it commits, full frames go out on valid/ready.
module seg7_scan_reader #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_reader_if.slave  bus
);
    typedef enum logic {S_COLLECT, S_HOLD} state_e;

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    // Returns {ok, blank, err, nibble}.
    function automatic logic [6:0] decode(input logic [6:0] p);
        logic [6:0] r;
        r = 7'b001_0000;
        case (p)
            7'b100_0000: r = {3'b100, 4'h0};
            7'b111_1001: r = {3'b100, 4'h1};
            7'b010_0100: r = {3'b100, 4'h2};
            7'b011_0000: r = {3'b100, 4'h3};
            7'b001_1001: r = {3'b100, 4'h4};
            7'b001_0010: r = {3'b100, 4'h5};
            7'b000_0010: r = {3'b100, 4'h6};
            7'b111_1000: r = {3'b100, 4'h7};
            7'b000_0000: r = {3'b100, 4'h8};
            7'b001_1000: r = {3'b100, 4'h9};
            7'b000_1000: r = {3'b100, 4'hA};
            7'b000_0011: r = {3'b100, 4'hB};
            7'b100_0110: r = {3'b100, 4'hC};
            7'b010_0001: r = {3'b100, 4'hD};
            7'b000_0110: r = {3'b100, 4'hE};
            7'b000_1110: r = {3'b100, 4'hF};
            7'b111_1111: r = {3'b010, 4'h0};
            default:     r = {3'b001, 4'h0};
        endcase
        return r;
    endfunction

    state_e                        state_q, state_d;
    logic [NUM_DIGITS-1:0][6:0]    last_pat_q, last_pat_d;
    logic [NUM_DIGITS-1:0][3:0]    cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]    digit_q, digit_d;
    logic [NUM_DIGITS-1:0]         ok_q, ok_d, blank_q, blank_d, err_q, err_d;
    logic [NUM_DIGITS-1:0]         committed_q, committed_d;
    logic [4*NUM_DIGITS-1:0]       out_value_q, out_value_d;
    logic [NUM_DIGITS-1:0]         out_ok_q, out_ok_d, out_blank_q, out_blank_d;
    logic [NUM_DIGITS-1:0]         out_err_q, out_err_d;
    logic                          out_valid_q, out_valid_d;

    logic [NUM_DIGITS-1:0]         commit_vec;
    logic                          sample_ok;
    int                            zeros;
    logic [6:0]                    dec;

    always_comb begin
        state_d     = state_q;
        last_pat_d  = last_pat_q;
        cnt_d       = cnt_q;
        digit_d     = digit_q;
        ok_d        = ok_q;
        blank_d     = blank_q;
        err_d       = err_q;
        out_value_d = out_value_q;
        out_ok_d    = out_ok_q;
        out_blank_d = out_blank_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        commit_vec  = '0;
        dec         = decode(bus.segments);

        // Only a single selected digit is a meaningful sample.
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!bus.an[i]) zeros = zeros + 1;
        sample_ok = bus.sample_en && (zeros == 1);

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sample_ok && !bus.an[i]) begin
                if (bus.segments == last_pat_q[i]) begin
                    if (cnt_q[i] != STABLE) begin
                        cnt_d[i]      = cnt_q[i] + 4'd1;
                        commit_vec[i] = ((cnt_q[i] + 4'd1) == STABLE);
                    end
                end else begin
                    last_pat_d[i] = bus.segments;
                    cnt_d[i]      = 4'd1;
                    commit_vec[i] = (STABLE == 4'd1);
                end
            end
            if (commit_vec[i]) begin
                {ok_d[i], blank_d[i], err_d[i], digit_d[i]} = dec;
            end
        end

        committed_d = committed_q | commit_vec;

        case (state_q)
            S_COLLECT: begin
                if (&committed_q) begin
                    out_value_d = digit_q;
                    out_ok_d    = ok_q;
                    out_blank_d = blank_q;
                    out_err_d   = err_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                // A digit committing on the handshake edge stays committed.
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    committed_d = commit_vec;
                    state_d     = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            last_pat_q  <= {NUM_DIGITS{7'b111_1111}};
            cnt_q       <= '0;
            digit_q     <= '0;
            ok_q        <= '0;
            blank_q     <= '0;
            err_q       <= '0;
            committed_q <= '0;
            out_value_q <= '0;
            out_ok_q    <= '0;
            out_blank_q <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_pat_q  <= last_pat_d;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            ok_q        <= ok_d;
            blank_q     <= blank_d;
            err_q       <= err_d;
            committed_q <= committed_d;
            out_value_q <= out_value_d;
            out_ok_q    <= out_ok_d;
            out_blank_q <= out_blank_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_value      = out_value_q;
    assign bus.out_ok_mask    = out_ok_q;
    assign bus.out_blank_mask = out_blank_q;
    assign bus.out_err_mask   = out_err_q;
    assign bus.out_valid      = out_valid_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: expected frames are queued as the
// display is driven and compared when out_valid appears.
module tb_seg7_scan_reader;
    localparam int ND = 4;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  ok;
        logic [3:0]  bl;
        logic [3:0]  er;
    } frame_t;

    localparam logic [6:0] SEG [16] = '{
        7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
        7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
        7'b000_0000, 7'b001_1000, 7'b000_1000, 7'b000_0011,
        7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
    };
    localparam logic [6:0] BLANK = 7'b111_1111;
    localparam logic [6:0] ILL   = 7'b111_0000;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;
    frame_t sb[$];

    seg7_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CNT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic smp(input int d, input logic [6:0] p);
        logic [ND-1:0] a;
        a = '1;
        a[d] = 1'b0;
        @(negedge clk);
        bus.an = a;
        bus.segments = p;
        bus.sample_en = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.an = '1;
    endtask

    task automatic scan(input logic [6:0] p0, p1, p2, p3, input int rounds);
        for (int r = 0; r < rounds; r++) begin
            smp(0, p0); smp(1, p1); smp(2, p2); smp(3, p3);
        end
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] ok, bl, er);
        frame_t f;
        f.v = v; f.ok = ok; f.bl = bl; f.er = er;
        sb.push_back(f);
    endtask

    task automatic wait_frame(input string tag, input bit hs);
        frame_t e;
        int n;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_value"}, 32'(bus.out_value), 32'(e.v));
            chk({tag, "_ok"}, 32'(bus.out_ok_mask), 32'(e.ok));
            chk({tag, "_blank"}, 32'(bus.out_blank_mask), 32'(e.bl));
            chk({tag, "_err"}, 32'(bus.out_err_mask), 32'(e.er));
        end
        if (hs) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.an = '1;
        bus.segments = BLANK;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_value", 32'(bus.out_value), 32'd0);
        chk("rst_masks", 32'({bus.out_ok_mask, bus.out_blank_mask, bus.out_err_mask}), 32'd0);
        rst_n = 1'b1;

        // Frame 1: 1, A, 7, F; out_valid one cycle after the last commit edge.
        push(16'hF7A1, 4'hF, 4'h0, 4'h0);
        scan(SEG[1], SEG[10], SEG[7], SEG[15], 3);
        idle();
        chk("f1_lat0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("f1_lat1", 32'(bus.out_valid), 32'd1);
        wait_frame("f1", 1'b0);

        // Held frame stays frozen; digit 2 commits on the handshake edge.
        repeat (50) @(negedge clk);
        chk("f1_hold_valid", 32'(bus.out_valid), 32'd1);
        smp(2, SEG[3]);
        smp(2, SEG[3]);
        @(negedge clk);
        chk("f1_frozen", 32'(bus.out_value), 32'hF7A1);
        bus.an = 4'b1011;
        bus.segments = SEG[3];
        bus.sample_en = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.sample_en = 1'b0;
        bus.an = '1;
        chk("f1_hs_drop", 32'(bus.out_valid), 32'd0);
        chk("f1_hs_value", 32'(bus.out_value), 32'hF7A1);

        // Frame 2: digit 2 already committed as 3, others re-commit.
        push(16'hC398, 4'hF, 4'h0, 4'h0);
        scan(SEG[8], SEG[9], SEG[3], SEG[12], 3);
        idle();
        wait_frame("f2", 1'b1);

        // Digit 1 toggling never commits; then hold 2. Blank and illegal digits.
        for (int r = 0; r < 4; r++) begin
            smp(0, ILL);
            smp(1, (r == 3 || r == 1) ? SEG[1] : SEG[2]);
            smp(2, SEG[5]);
            smp(3, BLANK);
        end
        idle();
        repeat (3) @(negedge clk);
        chk("toggle_no_frame", 32'(bus.out_valid), 32'd0);
        push(16'h0520, 4'b0110, 4'b1000, 4'b0001);
        smp(1, SEG[2]); smp(1, SEG[2]); smp(1, SEG[2]);
        idle();
        wait_frame("f3", 1'b1);

        // Unqualified samples must not touch the stability counters.
        scan(SEG[4], SEG[6], SEG[14], SEG[13], 2);
        repeat (20) begin
            @(negedge clk);
            bus.an = 4'b1111; bus.segments = SEG[8]; bus.sample_en = 1'b1;
        end
        repeat (20) begin
            @(negedge clk);
            bus.an = 4'b0011; bus.segments = SEG[8]; bus.sample_en = 1'b1;
        end
        repeat (20) begin
            @(negedge clk);
            bus.an = 4'b1110; bus.segments = SEG[4]; bus.sample_en = 1'b0;
        end
        idle();
        chk("ignored_no_frame", 32'(bus.out_valid), 32'd0);
        push(16'hDE64, 4'hF, 4'h0, 4'h0);
        scan(SEG[4], SEG[6], SEG[14], SEG[13], 1);
        idle();
        chk("f4_lat0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("f4_lat1", 32'(bus.out_valid), 32'd1);
        wait_frame("f4", 1'b0);

        // Reset wins over a pending handshake.
        @(negedge clk);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_value", 32'(bus.out_value), 32'd0);
        chk("mid_rst_masks", 32'({bus.out_ok_mask, bus.out_blank_mask, bus.out_err_mask}), 32'd0);
        scan(SEG[0], SEG[1], SEG[2], SEG[3], 2);
        idle();
        repeat (3) @(negedge clk);
        chk("post_rst_two_samples", 32'(bus.out_valid), 32'd0);
        push(16'h3210, 4'hF, 4'h0, 4'h0);
        scan(SEG[0], SEG[1], SEG[2], SEG[3], 1);
        idle();
        wait_frame("f5", 1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
